mem_issue_scheduler: RTL and testbench
======================================

MEM_ISSUE_SCHEDULER -- requirements
Module: mem_issue_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning load/store queue entries (power of two, 2..16).
REQ-002 SHALL have parameter LATENCY, default 1, meaning mem_exec_unit result latency in cycles (0..4).
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port i_push_valid  input  1  dispatch writes one ready load/store entry.
REQ-006 SHALL have port i_push_data  input  $bits(ld_st_fifo_data)  entry payload.
REQ-007 SHALL have port o_full  output  1  queue holds DEPTH entries.
REQ-008 SHALL have port o_cdb_req  output  1  head is a load requesting a CDB slot.
REQ-009 SHALL have port i_cdb_grant  input  1  CDB arbiter grants the load slot this cycle.
REQ-010 SHALL have port o_issue_granted  output  1  drives mem_exec_unit issue_granted.
REQ-011 SHALL have port o_issue_data  output  $bits(ld_st_fifo_data)  drives mem_exec_fifo_data.
REQ-012 SHALL have port i_mem_valid  input  1  cdb_valid from mem_exec_unit output (load retired).
REQ-013 SHALL have port i_flush  input  1  mispredict flush; discards queued, unissued entries.
REQ-014 SHALL have port o_idle  output  1  queue empty and zero loads in flight.

Function
REQ-015 SHALL store entries in a circular FIFO (wr_ptr, rd_ptr, count of width clog2(DEPTH)+1); pointers wrap from DEPTH-1 to 0.
REQ-016 SHALL accept a push when i_push_valid and not o_full; a push while full SHALL be dropped, state unchanged.
REQ-017 SHALL, when full, accept a push in the same cycle as an issue-pop (count unchanged).
REQ-018 SHALL implement FSM states IDLE, ST_ISSUE, LD_REQ.
REQ-019 SHALL sit in IDLE when count==0; on nonzero count go to ST_ISSUE if head ld_st_opcode==1, else LD_REQ.
REQ-020 SHALL, in ST_ISSUE, assert o_issue_granted for exactly one cycle with head data, pop it, and re-evaluate the next head.
REQ-021 SHALL, in LD_REQ, hold o_cdb_req=1; on i_cdb_grant assert o_issue_granted that cycle, pop, re-evaluate; without grant, hold head and o_issue_granted=0.
REQ-022 SHALL issue at most one entry per cycle, strictly in program order (no load bypassing a store).
REQ-023 SHALL present o_issue_data as head entry whenever count>0; all-zero otherwise.
REQ-024 SHALL keep an in-flight load counter (width clog2(LATENCY+2)): +1 on load issue, -1 on i_mem_valid, unchanged when both.
REQ-025 SHALL assert o_idle combinationally when count==0 and in-flight==0.
REQ-026 SHALL, on i_flush, clear count/pointers, enter IDLE, drop o_cdb_req next cycle; a push in the flush cycle SHALL be discarded; an issue in the flush cycle SHALL still complete.
REQ-027 SHALL NOT cancel loads already issued on flush; in-flight counter keeps tracking them.
REQ-028 SHALL ignore i_cdb_grant when not in LD_REQ.

Reset
REQ-029 SHALL, on rst, set count=0, pointers=0, in-flight=0, state IDLE.
REQ-030 SHALL hold o_full=0, o_cdb_req=0, o_issue_granted=0, o_issue_data=0, o_idle=1 during and after reset until a push.
REQ-031 SHALL give rst priority over i_flush and i_push_valid; reset mid-request SHALL drop the request without issue.

Structure
REQ-032 SHALL take ld_st_fifo_data and cdb_bfm from the shared utils package; FSM state enum SHALL be added there.
REQ-033 SHALL use one sub-module, mem_ld_st_queue (parameterized circular FIFO); FSM and counters live in the top.

Verification
REQ-034 SHALL cover: push store(rs1=0x10,imm=4) -> o_issue_granted one cycle later, o_cdb_req never asserted.
REQ-035 SHALL cover: push load, grant held low 3 cycles -> o_cdb_req high 3 cycles, issue on 4th-cycle grant, o_idle after i_mem_valid.
REQ-036 SHALL cover: push 4 entries (DEPTH=4) -> o_full=1; 5th push dropped; push+issue same cycle keeps count=4.
REQ-037 SHALL cover: sequence ST,LD,ST with grant always high -> issues in exact order on 3 consecutive cycles.
REQ-038 SHALL cover: flush with 3 queued and 1 load in flight -> count=0 next cycle, o_idle only after i_mem_valid.
REQ-039 SHALL cover: rst asserted during LD_REQ -> o_cdb_req=0 and o_issue_granted=0 next cycle, o_idle=1.

Source files
------------

// File: rtl/mem_issue_scheduler_pkg.sv
// Shared types for the memory issue scheduler: queue entry payload, CDB beat
// and the scheduler FSM state encoding.
package mem_issue_scheduler_pkg;

    typedef struct packed {
        logic        ld_st_opcode;   // 1 = store, 0 = load
        logic [31:0] rs1;
        logic [15:0] imm;
        logic [4:0]  rob_tag;
    } ld_st_fifo_data;

    typedef struct packed {
        logic        valid;
        logic [4:0]  tag;
        logic [31:0] data;
    } cdb_bfm;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ST_ISSUE = 2'd1,
        LD_REQ   = 2'd2
    } sched_state_e;

    localparam logic OP_STORE = 1'b1;

    function automatic logic is_store(input ld_st_fifo_data e);
        return e.ld_st_opcode == OP_STORE;
    endfunction

endpackage

// File: rtl/mem_issue_scheduler_if.sv
// Dispatch / CDB / mem_exec_unit handshake bundle for the memory issue scheduler.
interface mem_issue_scheduler_if;
    import mem_issue_scheduler_pkg::*;

    logic           i_push_valid;
    ld_st_fifo_data i_push_data;
    logic           o_full;
    logic           o_cdb_req;
    logic           i_cdb_grant;
    logic           o_issue_granted;
    ld_st_fifo_data o_issue_data;
    logic           i_mem_valid;
    logic           i_flush;
    logic           o_idle;

    modport slave (
        input  i_push_valid, i_push_data, i_cdb_grant, i_mem_valid, i_flush,
        output o_full, o_cdb_req, o_issue_granted, o_issue_data, o_idle
    );

    modport master (
        output i_push_valid, i_push_data, i_cdb_grant, i_mem_valid, i_flush,
        input  o_full, o_cdb_req, o_issue_granted, o_issue_data, o_idle
    );

endinterface

// File: rtl/mem_issue_scheduler_ld_st_queue.sv
// Circular load/store FIFO with a registered head and a look-ahead view of the
// next head so the scheduler FSM can pick its next state without a bubble.
module mem_ld_st_queue
    import mem_issue_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  ld_st_fifo_data         push_data_i,
    output ld_st_fifo_data         head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   nxt_empty_o,
    output logic                   nxt_head_store_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ld_st_fifo_data mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    ld_st_fifo_data head_q, head_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = '0;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
        // The entry written this cycle becomes the head when it lands on the next read slot
        if (count_d != '0)
            head_d = (push_i && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i)
            mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head_o           = head_q;
    assign count_o          = count_q;
    assign full_o           = (count_q == CW'(DEPTH));
    assign nxt_empty_o      = (count_d == '0);
    assign nxt_head_store_o = is_store(head_d);

endmodule

// File: rtl/mem_issue_scheduler.sv
// In-order load/store issue scheduler: stores issue directly, loads wait for a
// CDB slot grant; tracks loads in flight in mem_exec_unit.
module mem_issue_scheduler
    import mem_issue_scheduler_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_issue_scheduler_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(LATENCY + 2);

    sched_state_e   state_q;
    logic           cdb_req_q;
    logic [IW-1:0]  inflight_q, inflight_d;
    ld_st_fifo_data head;
    logic [CW-1:0]  count;
    logic           full;
    logic           nxt_empty;
    logic           nxt_head_store;
    logic           issue;
    logic           push_acc;
    logic           load_issue;

    assign issue      = !rst && ((state_q == ST_ISSUE) || ((state_q == LD_REQ) && bus.i_cdb_grant));
    // A full queue still takes a push when the head leaves in the same cycle
    assign push_acc   = bus.i_push_valid && !bus.i_flush && (!full || issue);
    assign load_issue = issue && !is_store(head);

    mem_ld_st_queue #(.DEPTH(DEPTH)) u_queue (
        .clk              (clk),
        .srst             (rst),
        .flush_i          (bus.i_flush),
        .push_i           (push_acc),
        .pop_i            (issue),
        .push_data_i      (bus.i_push_data),
        .head_o           (head),
        .count_o          (count),
        .full_o           (full),
        .nxt_empty_o      (nxt_empty),
        .nxt_head_store_o (nxt_head_store)
    );

    // State follows the head the queue will present next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cdb_req_q <= 1'b0;
        end else if (bus.i_flush || nxt_empty) begin
            state_q   <= IDLE;
            cdb_req_q <= 1'b0;
        end else if (nxt_head_store) begin
            state_q   <= ST_ISSUE;
            cdb_req_q <= 1'b0;
        end else begin
            state_q   <= LD_REQ;
            cdb_req_q <= 1'b1;
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (load_issue && !bus.i_mem_valid)
            inflight_d = inflight_q + IW'(1);
        else if (!load_issue && bus.i_mem_valid && (inflight_q != '0))
            inflight_d = inflight_q - IW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) inflight_q <= '0;
        else     inflight_q <= inflight_d;
    end

    assign bus.o_full          = !rst && full;
    assign bus.o_cdb_req       = !rst && cdb_req_q;
    assign bus.o_issue_granted = issue;
    assign bus.o_issue_data    = rst ? '0 : head;
    assign bus.o_idle          = rst || ((count == '0) && (inflight_q == '0));

endmodule

// File: tb/tb_mem_issue_scheduler.sv
// Scoreboard bench for mem_issue_scheduler: stimulus queues expected issues,
// a negedge monitor pops and compares every o_issue_granted beat.
module tb_mem_issue_scheduler;
    import mem_issue_scheduler_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    ld_st_fifo_data exp_q[$];
    ld_st_fifo_data mon_e;

    mem_issue_scheduler_if bus();

    mem_issue_scheduler #(.DEPTH(4), .LATENCY(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic ld_st_fifo_data mk(input logic op, input logic [31:0] rs1,
                                          input logic [15:0] imm, input logic [4:0] tag);
        ld_st_fifo_data r;
        r.ld_st_opcode = op;
        r.rs1          = rs1;
        r.imm          = imm;
        r.rob_tag      = tag;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got=%0h required=%0h", name, act, req);
        end else begin
            $display("check %s ok value=%0h", name, act);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input ld_st_fifo_data d, input bit expect_issue);
        bus.i_push_valid = 1'b1;
        bus.i_push_data  = d;
        if (expect_issue) exp_q.push_back(d);
    endtask

    // Monitor: every issue beat must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.o_issue_granted === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got=%0h required=none", bus.o_issue_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.o_issue_data !== mon_e) begin
                    errors++;
                    $display("FAIL issue_data: got=%0h required=%0h", bus.o_issue_data, mon_e);
                end else begin
                    $display("issue ok tag=%0d op=%0d", mon_e.rob_tag, mon_e.ld_st_opcode);
                end
            end
        end
    end

    initial begin
        rst              = 1'b1;
        bus.i_push_valid = 1'b1;
        bus.i_push_data  = mk(1'b1, 32'hdead, 16'h1, 5'd31);
        bus.i_cdb_grant  = 1'b0;
        bus.i_mem_valid  = 1'b0;
        bus.i_flush      = 1'b0;

        // Reset, with a push held that must be ignored
        @(negedge clk);
        chk("rst_idle",    64'(bus.o_idle), 64'd1);
        chk("rst_full",    64'(bus.o_full), 64'd0);
        chk("rst_cdb_req", 64'(bus.o_cdb_req), 64'd0);
        chk("rst_granted", 64'(bus.o_issue_granted), 64'd0);
        chk("rst_data",    64'(bus.o_issue_data), 64'd0);
        next_cycle();
        rst = 1'b0;
        bus.i_push_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 64'(bus.o_idle), 64'd1);
        chk("post_rst_data", 64'(bus.o_issue_data), 64'd0);
        next_cycle();

        // Store issues one cycle after push, no CDB request
        drive_push(mk(1'b1, 32'h10, 16'h4, 5'd1), 1'b1);
        next_cycle();
        bus.i_push_valid = 1'b0;
        @(negedge clk);
        chk("st_granted", 64'(bus.o_issue_granted), 64'd1);
        chk("st_cdb_req", 64'(bus.o_cdb_req), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("st_done_granted", 64'(bus.o_issue_granted), 64'd0);
        chk("st_done_cdb_req", 64'(bus.o_cdb_req), 64'd0);
        chk("st_done_idle",    64'(bus.o_idle), 64'd1);
        next_cycle();

        // Load waits three cycles for grant, idle only after retirement
        drive_push(mk(1'b0, 32'h20, 16'h8, 5'd2), 1'b1);
        next_cycle();
        bus.i_push_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("ld_wait_cdb_req", 64'(bus.o_cdb_req), 64'd1);
            chk("ld_wait_granted", 64'(bus.o_issue_granted), 64'd0);
            next_cycle();
        end
        bus.i_cdb_grant = 1'b1;
        @(negedge clk);
        chk("ld_grant_granted", 64'(bus.o_issue_granted), 64'd1);
        chk("ld_grant_idle",    64'(bus.o_idle), 64'd0);
        next_cycle();
        bus.i_cdb_grant = 1'b0;
        bus.i_mem_valid = 1'b1;
        @(negedge clk);
        chk("ld_inflight_cdb_req", 64'(bus.o_cdb_req), 64'd0);
        chk("ld_inflight_idle",    64'(bus.o_idle), 64'd0);
        next_cycle();
        bus.i_mem_valid = 1'b0;
        @(negedge clk);
        chk("ld_retired_idle", 64'(bus.o_idle), 64'd1);
        next_cycle();

        // Fill to full, drop a fifth push, then push+issue while full
        for (int i = 0; i < 4; i++) begin
            drive_push(mk(1'b0, 32'h100 + 32'(i), 16'h0, 5'(3 + i)), 1'b1);
            next_cycle();
        end
        drive_push(mk(1'b0, 32'h200, 16'h0, 5'd7), 1'b0);
        @(negedge clk);
        chk("fill_full", 64'(bus.o_full), 64'd1);
        next_cycle();
        drive_push(mk(1'b0, 32'h300, 16'h0, 5'd8), 1'b1);
        bus.i_cdb_grant = 1'b1;
        @(negedge clk);
        chk("drop_full", 64'(bus.o_full), 64'd1);
        next_cycle();
        bus.i_push_valid = 1'b0;
        bus.i_mem_valid  = 1'b1;
        @(negedge clk);
        chk("push_pop_full", 64'(bus.o_full), 64'd1);
        repeat (4) next_cycle();
        bus.i_cdb_grant = 1'b0;
        next_cycle();
        bus.i_mem_valid = 1'b0;
        @(negedge clk);
        chk("drain_idle", 64'(bus.o_idle), 64'd1);
        next_cycle();

        // ST, LD, ST with grant held: three consecutive in-order issues
        bus.i_cdb_grant = 1'b1;
        drive_push(mk(1'b1, 32'h40, 16'h1, 5'd9), 1'b1);
        next_cycle();
        drive_push(mk(1'b0, 32'h44, 16'h2, 5'd10), 1'b1);
        @(negedge clk);
        chk("seq_c1_granted", 64'(bus.o_issue_granted), 64'd1);
        next_cycle();
        drive_push(mk(1'b1, 32'h48, 16'h3, 5'd11), 1'b1);
        @(negedge clk);
        chk("seq_c2_granted", 64'(bus.o_issue_granted), 64'd1);
        chk("seq_c2_cdb_req", 64'(bus.o_cdb_req), 64'd1);
        next_cycle();
        bus.i_push_valid = 1'b0;
        bus.i_mem_valid  = 1'b1;
        @(negedge clk);
        chk("seq_c3_granted", 64'(bus.o_issue_granted), 64'd1);
        chk("seq_c3_cdb_req", 64'(bus.o_cdb_req), 64'd0);
        next_cycle();
        bus.i_mem_valid = 1'b0;
        bus.i_cdb_grant = 1'b0;
        @(negedge clk);
        chk("seq_end_granted", 64'(bus.o_issue_granted), 64'd0);
        chk("seq_end_idle",    64'(bus.o_idle), 64'd1);
        next_cycle();

        // Flush with three queued loads and one in flight
        drive_push(mk(1'b0, 32'h50, 16'h0, 5'd12), 1'b1);
        next_cycle();
        bus.i_push_valid = 1'b0;
        bus.i_cdb_grant  = 1'b1;
        @(negedge clk);
        chk("fl_issue_granted", 64'(bus.o_issue_granted), 64'd1);
        next_cycle();
        bus.i_cdb_grant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(mk(1'b0, 32'h60 + 32'(i), 16'h0, 5'(13 + i)), 1'b0);
            next_cycle();
        end
        drive_push(mk(1'b1, 32'h70, 16'h0, 5'd16), 1'b0);
        bus.i_flush = 1'b1;
        @(negedge clk);
        chk("fl_pre_cdb_req", 64'(bus.o_cdb_req), 64'd1);
        chk("fl_pre_idle",    64'(bus.o_idle), 64'd0);
        next_cycle();
        bus.i_push_valid = 1'b0;
        bus.i_flush      = 1'b0;
        bus.i_cdb_grant  = 1'b1;
        bus.i_mem_valid  = 1'b1;
        @(negedge clk);
        chk("fl_post_cdb_req", 64'(bus.o_cdb_req), 64'd0);
        chk("fl_post_data",    64'(bus.o_issue_data), 64'd0);
        chk("fl_post_full",    64'(bus.o_full), 64'd0);
        chk("fl_post_idle",    64'(bus.o_idle), 64'd0);
        next_cycle();
        bus.i_mem_valid = 1'b0;
        bus.i_cdb_grant = 1'b0;
        @(negedge clk);
        chk("fl_retired_idle", 64'(bus.o_idle), 64'd1);
        next_cycle();

        // Reset while a load is requesting the CDB
        drive_push(mk(1'b0, 32'h80, 16'h0, 5'd17), 1'b0);
        next_cycle();
        bus.i_push_valid = 1'b0;
        @(negedge clk);
        chk("rq_cdb_req", 64'(bus.o_cdb_req), 64'd1);
        next_cycle();
        rst             = 1'b1;
        bus.i_cdb_grant = 1'b1;
        @(negedge clk);
        chk("rq_rst_granted", 64'(bus.o_issue_granted), 64'd0);
        chk("rq_rst_cdb_req", 64'(bus.o_cdb_req), 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rq_after_cdb_req", 64'(bus.o_cdb_req), 64'd0);
        chk("rq_after_granted", 64'(bus.o_issue_granted), 64'd0);
        chk("rq_after_idle",    64'(bus.o_idle), 64'd1);
        next_cycle();
        bus.i_cdb_grant = 1'b0;

        repeat (2) next_cycle();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
